// File: rtl/shift_add_multiplier_8bit.sv
// Sequential 8x8 unsigned shift-and-add multiplier: IDLE -> RUN (one partial product per cycle) -> DONE.
// Optional early termination when the remaining multiplier bits are zero: define SHIFT_ADD_MUL_EARLY_TERM_EN.
module shift_add_multiplier_8bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] p
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] mcand_q, mcand_d;
  logic [7:0]  mplr_q, mplr_d;
  logic [15:0] acc_q, acc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] p_q, p_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [15:0] step_sum_s;
  logic        last_step_s;

  // Partial-product sum for the current step; the product never exceeds 16 bits.
  assign step_sum_s = acc_q + (mplr_q[0] ? mcand_q : 16'h0000);

`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
  // Stop as soon as no set multiplier bits remain after this step's shift.
  assign last_step_s = (mplr_q[7:1] == 7'd0) || (cnt_q == 3'd7);
`else
  assign last_step_s = (cnt_q == 3'd7);
`endif

  // Next-state, datapath and output decode.
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = {8'h00, a};
          mplr_d  = b;
          acc_d   = 16'h0000;
          cnt_d   = 3'd0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d   = step_sum_s;
        mcand_d = {mcand_q[14:0], 1'b0};
        mplr_d  = {1'b0, mplr_q[7:1]};
        cnt_d   = cnt_q + 3'd1;
        if (last_step_s) begin
          p_d     = step_sum_s;
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= 16'h0000;
      mplr_q  <= 8'h00;
      acc_q   <= 16'h0000;
      cnt_q   <= 3'd0;
      p_q     <= 16'h0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign p    = p_q;

endmodule

// File: tb/tb_shift_add_multiplier_8bit.sv
// Scoreboard bench for shift_add_multiplier_8bit; latency expectations follow SHIFT_ADD_MUL_EARLY_TERM_EN.
module tb_shift_add_multiplier_8bit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] p;

  int          checks;
  int          failures;
  logic [15:0] exp_q[$];

  shift_add_multiplier_8bit dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // busy and done must never be high together.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (busy && done) begin
        failures++;
        $display("FAIL busy_done_exclusive: busy=%0b done=%0b required not both 1", busy, done);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic int exp_lat(input logic [7:0] bb);
    int n;
    n = 8;
`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
    n = 1;
    for (int i = 0; i < 8; i++) begin
      if (bb[i]) n = i + 1;
    end
`endif
    return n;
  endfunction

  function automatic logic [15:0] ref_mul(input logic [7:0] aa, input logic [7:0] bb);
    logic [15:0] r;
    r = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      if (bb[i]) r = r + ({8'h00, aa} << i);
    end
    return r;
  endfunction

  // One-cycle start pulse from an idle DUT; returns at the negedge after the accepting edge.
  task automatic start_op(input logic [7:0] aa, input logic [7:0] bb, input logic [15:0] expv);
    @(negedge clk);
    a = aa;
    b = bb;
    start = 1'b1;
    exp_q.push_back(expv);
    @(negedge clk);
    start = 1'b0;
    a = 8'hA5;
    b = 8'h5A;
  endtask

  task automatic wait_done(input int bound, output int cyc, output bit seen, output int busy_cnt);
    cyc = 0;
    seen = 1'b0;
    busy_cnt = 0;
    while (cyc < bound && !seen) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1'b1;
      else if (busy) busy_cnt++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (p !== 16'h0000 || done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle: p=%h done=%b busy=%b required p=0000 done=0 busy=0", p, done, busy);
      end
    end
  endtask

  task automatic test_basic(input logic [7:0] aa, input logic [7:0] bb, input logic [15:0] expv);
    int cyc; bit seen; int bc; int lat; logic [15:0] e;
    lat = exp_lat(bb);
    start_op(aa, bb, expv);
    checks++;
    if (lat > 1 && busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy_start: busy=%b required 1 (a=%0d b=%0d)", busy, aa, bb);
    end
    wait_done(20, cyc, seen, bc);
    checks++;
    if (!seen || cyc !== lat) begin
      failures++;
      $display("FAIL basic_latency: seen=%0b cycles=%0d required %0d (a=%0d b=%0d)", seen, cyc, lat, aa, bb);
    end
    checks++;
    if (bc !== lat - 1) begin
      failures++;
      $display("FAIL basic_busy_cycles: got %0d required %0d", bc, lat - 1);
    end
    e = exp_q.pop_front();
    checks++;
    if (p !== e) begin
      failures++;
      $display("FAIL basic_product: p=%0d required %0d (a=%0d b=%0d)", p, e, aa, bb);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || p !== e) begin
      failures++;
      $display("FAIL basic_after_done: done=%b busy=%b p=%0d required 0 0 %0d", done, busy, p, e);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (p !== e) begin
      failures++;
      $display("FAIL basic_p_hold: p=%0d required %0d", p, e);
    end
  endtask

  task automatic test_start_ignored;
    int cyc; bit seen; int bc; int extra; logic [15:0] e;
    start_op(8'd12, 8'd10, 16'd120);
    repeat (2) @(negedge clk);
    a = 8'd7;
    b = 8'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(20, cyc, seen, bc);
    checks++;
    if (!seen || cyc !== exp_lat(8'd10) - 3) begin
      failures++;
      $display("FAIL ignore_latency: seen=%0b cycles=%0d required %0d", seen, cyc, exp_lat(8'd10) - 3);
    end
    e = exp_q.pop_front();
    checks++;
    if (p !== e) begin
      failures++;
      $display("FAIL ignore_product: p=%0d required %0d", p, e);
    end
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    checks++;
    if (extra !== 0) begin
      failures++;
      $display("FAIL ignore_single_done: extra done pulses=%0d required 0", extra);
    end
  endtask

  task automatic test_reset_abort;
    int cnt; logic [15:0] dropped;
    start_op(8'd9, 8'd9, 16'd81);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    dropped = exp_q.pop_back();
    checks++;
    if (p !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL abort_async: p=%h busy=%b done=%b required 0000 0 0 (dropped %0d)", p, busy, done, dropped);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || p !== 16'h0000) cnt++;
    end
    checks++;
    if (cnt !== 0) begin
      failures++;
      $display("FAIL abort_no_done: bad cycles=%0d required 0", cnt);
    end
    test_basic(8'd2, 8'd3, 16'd6);
  endtask

  task automatic test_back_to_back;
    logic [7:0] av[$];
    logic [7:0] bv[$];
    int cyc; bit seen; int bc; int want; logic [15:0] e;
    av = '{8'd0, 8'd0, 8'd255, 8'd1, 8'd200, 8'd255, 8'd255, 8'd1, 8'd128, 8'd77};
    bv = '{8'd0, 8'd255, 8'd0, 8'd1, 8'd0, 8'd128, 8'd255, 8'd255, 8'd2, 8'd1};
    for (int i = 0; i < 1000; i++) begin
      av.push_back(8'($urandom_range(255, 0)));
      bv.push_back(8'($urandom_range(255, 0)));
    end
    @(negedge clk);
    a = av[0];
    b = bv[0];
    start = 1'b1;
    exp_q.push_back(ref_mul(av[0], bv[0]));
    for (int k = 0; k < av.size(); k++) begin
      want = exp_lat(bv[k]) + ((k == 0) ? 1 : 2);
      wait_done(30, cyc, seen, bc);
      checks++;
      if (!seen || cyc !== want) begin
        failures++;
        $display("FAIL b2b_spacing[%0d]: seen=%0b cycles=%0d required %0d", k, seen, cyc, want);
      end
      e = exp_q.pop_front();
      checks++;
      if (p !== e) begin
        failures++;
        $display("FAIL b2b_product[%0d]: a=%0d b=%0d p=%0d required %0d", k, av[k], bv[k], p, e);
      end
      if (!seen) break;
      if (k + 1 < av.size()) begin
        a = av[k + 1];
        b = bv[k + 1];
        exp_q.push_back(ref_mul(av[k + 1], bv[k + 1]));
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (exp_q.size() !== 0 || done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain: queue=%0d done=%b required 0 0", exp_q.size(), done);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    test_reset();
    test_basic(8'd3, 8'd5, 16'd15);
    test_basic(8'd255, 8'd255, 16'hFE01);
    test_basic(8'd200, 8'd0, 16'd0);
    test_basic(8'd37, 8'h80, 16'd4736);
    test_basic(8'd255, 8'd1, 16'd255);
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier_8bit.md
SHIFT_ADD_MULTIPLIER_8BIT -- requirements
Module: shift_add_multiplier_8bit

Interface
- No parameters; all operand and result widths are fixed.
- REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
- REQ-002 Port `clk`: input, 1 bit, the single clock. All state SHALL update on the rising edge.
- REQ-003 Port `rst`: input, 1 bit, asynchronous active-high reset.
- REQ-004 Port `start`: input, 1 bit, request to begin a multiply. It SHALL be sampled on a rising edge.
- REQ-005 Port `a`: input, 8 bits, unsigned multiplicand. It SHALL be sampled with `start`.
- REQ-006 Port `b`: input, 8 bits, unsigned multiplier. It SHALL be sampled with `start`.
- REQ-007 Port `busy`: output, 1 bit, high while in state RUN.
- REQ-008 Port `done`: output, 1 bit, high for exactly one cycle when `p` is valid and new.
- REQ-009 Port `p`: output, 16 bits, registered product of the last completed operation.

Function
- REQ-010 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
- REQ-011 In IDLE, if `start` = 1 at edge N, the block SHALL do all of the following at that edge:
  - latch `a` zero-extended to 16 bits into `mcand`;
  - latch `b` into `mplr`;
  - clear `acc`;
  - clear the 3-bit `cnt`;
  - enter RUN.
- REQ-012 Each RUN edge SHALL perform one step:
  - `acc` += `mcand` if `mplr[0]` = 1;
  - `mcand` shifts left by 1;
  - `mplr` shifts right by 1;
  - `cnt` increments.
- REQ-013 Additions SHALL be 16-bit unsigned. The sum cannot exceed 65025, so there is no carry-out and no overflow flag.
- REQ-014 RUN SHALL exit to DONE on the edge that performs step 8 (`cnt` = 7).
- REQ-015 On that same edge, `p` SHALL be loaded with the post-step `acc` value.
- REQ-016 In DONE, `done` SHALL be 1 and `busy` SHALL be 0. DONE SHALL go to IDLE unconditionally on the next edge.
- REQ-017 Baseline latency: `start` sampled at edge N gives `done` = 1 and the new `p` from edge N+8 to edge N+9.
- REQ-018 `start` SHALL be ignored in RUN and DONE. It SHALL NOT restart the operation or corrupt the latched operands.
- REQ-019 `a` and `b` SHALL be don't-care except at the accepting edge. Changing them mid-operation SHALL NOT affect the result.
- REQ-020 `p` SHALL hold its value until the next completion, including through IDLE.
- REQ-021 Back-to-back operation: `start` held high SHALL be accepted at the first IDLE edge after DONE, i.e. every 10 cycles in the baseline build.
- REQ-022 `done` and `busy` SHALL never be 1 in the same cycle.

Reset
- REQ-023 When `rst` = 1, the block SHALL immediately, independent of `clk`, set:
  - state to IDLE;
  - `p` = 16'h0000;
  - `done` = 0 and `busy` = 0;
  - `acc`, `mcand`, `mplr` and `cnt` = 0.
- REQ-024 Reset asserted mid-RUN SHALL abort the operation. No `done` SHALL be produced and `p` SHALL read 0.
- REQ-025 After `rst` deasserts, the first `start` SHALL be accepted at the first rising edge where `start` = 1.

Configuration
- REQ-026 Macro `SHIFT_ADD_MUL_EARLY_TERM_EN` controls early termination.
  - Defined: RUN SHALL exit to DONE on the edge where the post-shift `mplr` is 0 or `cnt` = 7, whichever comes first. `p` SHALL be loaded on that edge.
  - Consequence when defined: `b` = 0 or `b` = 1 completes with `done` at edge N+1, and `b` = 8'h80 with `done` at edge N+8.
  - Not defined: RUN SHALL always take exactly 8 steps, per REQ-014.
  - The product value SHALL be identical in both builds.

Verification
- REQ-027 `rst` pulse, then idle 3 cycles -> `p` = 0, `done` = 0, `busy` = 0 throughout.
- REQ-028 `a` = 3, `b` = 5, `start` at edge N -> `busy` high from N to N+8, `p` = 15 with `done` = 1 at edge N+8 (baseline).
- REQ-029 `a` = 255, `b` = 255 -> `p` = 16'hFE01 (65025).
  - With the macro defined: `a` = 200, `b` = 0 -> `p` = 0 with `done` at edge N+1.
- REQ-030 `a` = 12, `b` = 10, then at N+3 pulse `start` with `a` = 7, `b` = 7 -> `p` = 120, and only one `done`.
- REQ-031 `a` = 9, `b` = 9, assert `rst` at N+4 -> `p` = 0 and no `done`. Then `a` = 2, `b` = 3 gives `p` = 6.
- REQ-032 Exhaustive sweep of all 65536 (`a`, `b`) pairs, `start` held high, each `p` checked against `a`*`b` at `done` -> zero mismatches. Run in both macro builds.
